// File: rtl/calc_pkg.sv
// Shared types for the 4-bit calculator: opcode encoding, operand-entry states and default width.
package calc_pkg;

    localparam int unsigned CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_EQ  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        GET_A   = 2'b00,
        GET_B   = 2'b01,
        GET_OP  = 2'b10,
        PRESENT = 2'b11
    } entry_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus counting debouncer for a raw pushbutton.
// Emits a single-cycle press pulse on each accepted 0->1 transition.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CountMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync;
    logic            stable;
    logic [CntW-1:0] count;

    always_ff @(posedge clock) begin
        if (clear) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            stable    <= 1'b0;
            count     <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
            press     <= 1'b0;
            if (sync != stable) begin
                if (count == CountMax) begin
                    // Accept the new level; pulse registered on the same edge it is accepted.
                    stable <= sync;
                    count  <= '0;
                    press  <= sync;
                end else begin
                    count <= count + CntW'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry stage: captures A, B and opcode on successive ENTER presses and
// presents the triple downstream with a valid/ready handshake.
module operand_entry_fsm
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH           = CALC_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       op_sw,
    input  logic             enter_btn,
    input  logic             ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [1:0]       op,
    output logic             valid,
    output logic [1:0]       phase
);

    entry_state_t state_q, state_d;
    logic         press;
    logic         cap_a, cap_b, cap_op;
    logic [WIDTH-1:0] a_q, b_q;
    op_t              op_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .clear   (clear),
        .btn_raw (enter_btn),
        .press   (press)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Presses while PRESENT fall through to the default hold and are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GET_A:   if (press) state_d = GET_B;
            GET_B:   if (press) state_d = GET_OP;
            GET_OP:  if (press) state_d = PRESENT;
            PRESENT: if (ready) state_d = GET_A;
            default: state_d = GET_A;
        endcase
    end

    always_comb begin
        cap_a  = press && (state_q == GET_A);
        cap_b  = press && (state_q == GET_B);
        cap_op = press && (state_q == GET_OP);
        valid  = (state_q == PRESENT);
        phase  = state_q;
        a      = a_q;
        b      = b_q;
        op     = op_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
        end else begin
            if (cap_a)  a_q  <= sw;
            if (cap_b)  b_q  <= sw;
            if (cap_op) op_q <= op_t'(op_sw);
        end
    end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Randomised scoreboard bench for operand_entry_fsm with a field-count reference model.
module tb_operand_entry_fsm;

    localparam int N = 16;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic [W-1:0] sw = '0;
    logic [1:0]   op_sw = '0;
    logic         enter_btn = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] a, b;
    logic [1:0]   op, phase;
    logic         valid;

    int checks = 0;
    int failures = 0;

    // Reference model: number of fields entered so far plus the captured values.
    int           m_fields = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [1:0]   m_op = '0;
    logic [9:0]   exp_q[$];

    operand_entry_fsm #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .sw        (sw),
        .op_sw     (op_sw),
        .enter_btn (enter_btn),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid     (valid),
        .phase     (phase)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name);
        logic [1:0] mp;
        mp = 2'(m_fields);
        check(name, {19'd0, valid, phase, a, b, op},
              {19'd0, (m_fields == 3), mp, m_a, m_b, m_op});
    endtask

    task automatic model_press();
        case (m_fields)
            0: begin m_a = sw; m_fields = 1; end
            1: begin m_b = sw; m_fields = 2; end
            2: begin m_op = op_sw; m_fields = 3; exp_q.push_back({m_a, m_b, m_op}); end
            default: ;
        endcase
    endtask

    task automatic model_transfer();
        if (m_fields == 3) m_fields = 0;
    endtask

    task automatic model_reset();
        m_fields = 0; m_a = '0; m_b = '0; m_op = '0;
        exp_q.delete();
    endtask

    // Hold the button for h sampled edges, release, and wait for the debouncer to settle low.
    task automatic btn_hold(input int h);
        @(posedge clock); #1 enter_btn = 1'b1;
        repeat (h) @(posedge clock);
        #1 enter_btn = 1'b0;
        repeat (N + 6) @(posedge clock);
    endtask

    task automatic press_field(input logic [W-1:0] s, input logic [1:0] o);
        sw = s; op_sw = o;
        btn_hold(N + 4);
        model_press();
    endtask

    task automatic transfer(input string name);
        @(posedge clock); #1 ready = 1'b1;
        @(posedge clock); #1 ready = 1'b0;
        model_transfer();
        @(negedge clock);
        check_state(name);
    endtask

    // Monitor: every accepted handshake must match the oldest expected triple.
    always @(negedge clock) begin
        if (!clear && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_transfer actual={a,b,op}=%0h required=none", {a, b, op});
            end else begin
                check("transfer_triple", {22'd0, a, b, op}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check("reset_a", {28'd0, a}, 32'd0);
        check("reset_b", {28'd0, b}, 32'd0);
        check("reset_op", {30'd0, op}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_phase", {30'd0, phase}, 32'd0);

        // Full entry with ready low, held then transferred.
        press_field(4'h3, 2'b00);
        press_field(4'h5, 2'b00);
        press_field(4'h0, 2'b01);
        check_state("full_entry");
        for (int i = 0; i < 5; i++) begin
            repeat (10) @(negedge clock);
            check_state("full_entry_hold");
        end
        transfer("full_entry_transfer");

        // Exact latency: no change after edge k+17, capture after edge k+18.
        sw = 4'h7;
        @(posedge clock); #1 enter_btn = 1'b1;
        repeat (18) @(posedge clock);
        @(negedge clock);
        check_state("latency_k17");
        @(posedge clock);
        model_press();
        @(negedge clock);
        check_state("latency_k18");
        #1 enter_btn = 1'b0;
        repeat (N + 6) @(posedge clock);
        press_field(4'hA, 2'b00);
        press_field(4'h0, 2'b10);
        transfer("latency_transfer");

        // Glitch of N-1 cycles rejected, N cycles accepted exactly once.
        sw = 4'hC;
        btn_hold(N - 1);
        @(negedge clock);
        check_state("glitch_short");
        btn_hold(N);
        model_press();
        @(negedge clock);
        check_state("glitch_exact");
        press_field(4'h1, 2'b00);
        press_field(4'h0, 2'b11);
        transfer("glitch_transfer");

        // Long hold yields one capture only.
        sw = 4'h6;
        btn_hold(500);
        model_press();
        @(negedge clock);
        check_state("held_button");
        press_field(4'h4, 2'b00);
        press_field(4'h0, 2'b01);

        // Presses in PRESENT are dropped, alone or coinciding with ready.
        press_field(4'hF, 2'b11);
        check_state("ignored_press");
        sw = 4'hE;
        @(posedge clock); #1 enter_btn = 1'b1;
        repeat (18) @(posedge clock);
        #1 ready = 1'b1;
        @(posedge clock); #1 ready = 1'b0;
        model_transfer();
        @(negedge clock);
        check_state("press_with_ready");
        #1 enter_btn = 1'b0;
        repeat (N + 6) @(posedge clock);
        @(negedge clock);
        check_state("press_with_ready_lost");

        // Mid-operation reset discards partial fields.
        press_field(4'h9, 2'b00);
        press_field(4'h2, 2'b00);
        check_state("pre_reset");
        @(posedge clock); #1 clear = 1'b1;
        @(posedge clock); #1 clear = 1'b0;
        model_reset();
        @(negedge clock);
        check_state("mid_reset");
        press_field(4'hB, 2'b00);
        press_field(4'hD, 2'b00);
        press_field(4'h0, 2'b10);
        transfer("post_reset_transfer");

        // Randomised entries; ready toggles randomly while nothing is valid.
        for (int t = 0; t < 8; t++) begin
            ready = 1'($urandom_range(0, 1));
            press_field(W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            press_field(W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            ready = 1'b0;
            sw = W'($urandom_range(0, 15)); op_sw = 2'($urandom_range(0, 3));
            btn_hold(N + int'($urandom_range(0, 8)));
            model_press();
            @(negedge clock);
            check_state("rand_present");
            repeat ($urandom_range(0, 5)) @(posedge clock);
            transfer("rand_transfer");
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
